// File: rtl/tlul_regbus_bridge.sv
// ----------------------------------------------------------------------------
// tlul_pkg: minimal TL-UL type definitions used by the bridge.
//   tl_h2d_t (86 bits): A channel + d_ready
//   tl_d2h_t (52 bits): D channel + a_ready
//
// tlul_regbus_bridge: TL-UL device-side bridge to a req/ack register bus.
//   One transaction in flight. Malformed requests are answered with an error
//   and never reach the register bus. A register access that is not
//   acknowledged within TIMEOUT cycles is aborted with an error.
//
// Ports
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   tl_i     TL-UL host-to-device (A channel, d_ready)
//   tl_o     TL-UL device-to-host (D channel, a_ready), fully registered
//   req_o    register access request, held until ack_i
//   we_o     1 = write (Put*), 0 = read (Get)
//   addr_o   word-aligned register byte address
//   wdata_o  write data
//   be_o     byte enables (4'hF for reads)
//   ack_i    register access complete (single-cycle pulse)
//   rdata_i  read data, valid with ack_i
//   error_i  access error, valid with ack_i
// ----------------------------------------------------------------------------
package tlul_pkg;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;

    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module tlul_regbus_bridge
    import tlul_pkg::*;
#(
    parameter int AW      = 12,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  tl_h2d_t       tl_i,
    output tl_d2h_t       tl_o,
    output logic          req_o,
    output logic          we_o,
    output logic [AW-1:0] addr_o,
    output logic [31:0]   wdata_o,
    output logic [3:0]    be_o,
    input  logic          ack_i,
    input  logic [31:0]   rdata_i,
    input  logic          error_i
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic             TO_EN   = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REG  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Byte lanes covered by an access of 2**size bytes starting at byte off.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            2'd0:    m = 4'b0001 << off;
            2'd1:    m = off[1] ? 4'b1100 : 4'b0011;
            2'd2:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Any protocol violation that must be answered without touching the bus.
    function automatic logic req_err(input logic [2:0] op, input logic [1:0] size,
                                     input logic [1:0] off, input logic [3:0] mask);
        logic is_put;
        logic bad_op;
        logic misalign;
        logic [3:0] lane;
        is_put = (op == PutFullData) || (op == PutPartialData);
        bad_op = !(is_put || (op == Get));
        case (size)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = off[0];
            2'd2:    misalign = |off;
            default: misalign = 1'b1;
        endcase
        lane = lane_mask(size, off);
        return bad_op
            || misalign
            || (is_put && (mask == 4'h0))
            || ((op == PutFullData) && (mask != lane))
            || ((mask & ~lane) != 4'h0);
    endfunction

    state_e            state_q, state_d;
    logic              a_ready_q, a_ready_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_get_q, is_get_d;
    logic              d_valid_q, d_valid_d;
    logic [2:0]        d_opcode_q, d_opcode_d;
    logic [1:0]        d_size_q, d_size_d;
    logic [7:0]        d_source_q, d_source_d;
    logic [31:0]       d_data_q, d_data_d;
    logic              d_error_q, d_error_d;

    logic              a_is_get_s;
    logic              a_err_s;
    logic              timeout_hit_s;
    logic              unused_tl_s;

    assign a_is_get_s    = (tl_i.a_opcode == Get);
    assign a_err_s       = req_err(tl_i.a_opcode, tl_i.a_size, tl_i.a_address[1:0], tl_i.a_mask);
    // Counter value on the last permitted REG cycle; ack on that same cycle still wins.
    assign timeout_hit_s = TO_EN && (cnt_q == TO_LAST);
    assign unused_tl_s   = ^{tl_i.a_param, tl_i.a_address};

    // Next-state and next-output logic for the IDLE/REG/RESP sequencer.
    always_comb begin
        state_d    = state_q;
        a_ready_d  = a_ready_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        cnt_d      = cnt_q;
        is_get_d   = is_get_q;
        d_valid_d  = d_valid_q;
        d_opcode_d = d_opcode_q;
        d_size_d   = d_size_q;
        d_source_d = d_source_q;
        d_data_d   = d_data_q;
        d_error_d  = d_error_q;

        case (state_q)
            ST_IDLE: begin
                a_ready_d = 1'b1;
                // Accept only when a_ready is visibly high to the host.
                if (tl_i.a_valid && a_ready_q) begin
                    a_ready_d  = 1'b0;
                    is_get_d   = a_is_get_s;
                    d_size_d   = tl_i.a_size;
                    d_source_d = tl_i.a_source;
                    d_opcode_d = a_is_get_s ? AccessAckData : AccessAck;
                    cnt_d      = '0;
                    if (a_err_s) begin
                        state_d   = ST_RESP;
                        d_valid_d = 1'b1;
                        d_error_d = 1'b1;
                        d_data_d  = a_is_get_s ? 32'hFFFF_FFFF : 32'h0000_0000;
                    end else begin
                        state_d = ST_REG;
                        req_d   = 1'b1;
                        we_d    = !a_is_get_s;
                        addr_d  = {tl_i.a_address[AW-1:2], 2'b00};
                        wdata_d = tl_i.a_data;
                        be_d    = a_is_get_s ? 4'hF : tl_i.a_mask;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_REG: begin
                a_ready_d = 1'b0;
                if (ack_i) begin
                    state_d   = ST_RESP;
                    req_d     = 1'b0;
                    d_valid_d = 1'b1;
                    d_error_d = error_i;
                    if (is_get_q) begin
                        d_data_d = error_i ? 32'hFFFF_FFFF : rdata_i;
                    end else begin
                        d_data_d = 32'h0000_0000;
                    end
                end else if (timeout_hit_s) begin
                    state_d   = ST_RESP;
                    req_d     = 1'b0;
                    d_valid_d = 1'b1;
                    d_error_d = 1'b1;
                    d_data_d  = is_get_q ? 32'hFFFF_FFFF : 32'h0000_0000;
                end else begin
                    state_d = ST_REG;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            ST_RESP: begin
                a_ready_d = 1'b0;
                if (tl_i.d_ready) begin
                    state_d   = ST_IDLE;
                    d_valid_d = 1'b0;
                    a_ready_d = 1'b1;
                end else begin
                    state_d = ST_RESP;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                a_ready_d = 1'b0;
                req_d     = 1'b0;
                d_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            a_ready_q  <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0000_0000;
            be_q       <= 4'h0;
            cnt_q      <= '0;
            is_get_q   <= 1'b0;
            d_valid_q  <= 1'b0;
            d_opcode_q <= 3'h0;
            d_size_q   <= 2'h0;
            d_source_q <= 8'h00;
            d_data_q   <= 32'h0000_0000;
            d_error_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_ready_q  <= a_ready_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            cnt_q      <= cnt_d;
            is_get_q   <= is_get_d;
            d_valid_q  <= d_valid_d;
            d_opcode_q <= d_opcode_d;
            d_size_q   <= d_size_d;
            d_source_q <= d_source_d;
            d_data_q   <= d_data_d;
            d_error_q  <= d_error_d;
        end
    end

    assign req_o   = req_q;
    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign be_o    = be_q;

    assign tl_o = '{
        d_valid:  d_valid_q,
        d_opcode: d_opcode_q,
        d_param:  3'h0,
        d_size:   d_size_q,
        d_source: d_source_q,
        d_sink:   1'b0,
        d_data:   d_data_q,
        d_error:  d_error_q,
        a_ready:  a_ready_q
    };

endmodule

// File: tb/tb_tlul_regbus_bridge.sv
// ----------------------------------------------------------------------------
// Testbench for tlul_regbus_bridge. Stimulus pushes expected register
// accesses and expected D-channel responses into queues; a register-bus
// responder and a D-channel monitor pop and compare independently.
// ----------------------------------------------------------------------------
module tb_tlul_regbus_bridge;
    import tlul_pkg::*;

    localparam int TO = 8;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    tl_h2d_t tl_i;
    tl_d2h_t tl_o;
    logic req_o, we_o;
    logic [AW-1:0] addr_o;
    logic [31:0] wdata_o;
    logic [3:0] be_o;
    logic ack_i = 1'b0;
    logic [31:0] rdata_i = 32'h0;
    logic error_i = 1'b0;

    logic        drv_valid = 1'b0;
    logic [2:0]  drv_op = 3'h0;
    logic [1:0]  drv_size = 2'h0;
    logic [7:0]  drv_src = 8'h0;
    logic [31:0] drv_addr = 32'h0;
    logic [3:0]  drv_mask = 4'h0;
    logic [31:0] drv_data = 32'h0;
    logic        drv_dready = 1'b0;

    assign tl_i = '{a_valid: drv_valid, a_opcode: drv_op, a_param: 3'h0, a_size: drv_size,
                    a_source: drv_src, a_address: drv_addr, a_mask: drv_mask,
                    a_data: drv_data, d_ready: drv_dready};

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [7:0]  src;
        logic [31:0] data;
        logic        err;
        int          cyc;
        int          hold;
    } rsp_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    be;
        int            dly;
        logic [31:0]   rd;
        logic          ei;
    } req_t;

    rsp_t rsp_q[$];
    req_t req_q[$];

    tlul_regbus_bridge #(.AW(AW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .tl_i(tl_i), .tl_o(tl_o),
        .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o),
        .ack_i(ack_i), .rdata_i(rdata_i), .error_i(error_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: bytes [off, off+2**size) of the word.
    function automatic logic [3:0] m_lane(input logic [1:0] size, input logic [31:0] addr);
        int nb;
        int off;
        logic [3:0] m;
        nb = 1 << size;
        off = int'(addr % 4);
        m = 4'h0;
        for (int b = 0; b < 4; b++) if (b >= off && b < off + nb) m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic m_err(input logic [2:0] op, input logic [1:0] size,
                                   input logic [31:0] addr, input logic [3:0] mask);
        logic put;
        put = (op == PutFullData) || (op == PutPartialData);
        if (!(put || op == Get)) return 1'b1;
        if (size > 2) return 1'b1;
        if ((addr % (32'd1 << size)) != 0) return 1'b1;
        if (put && mask == 4'h0) return 1'b1;
        if (op == PutFullData && mask != m_lane(size, addr)) return 1'b1;
        if ((mask & ~m_lane(size, addr)) != 4'h0) return 1'b1;
        return 1'b0;
    endfunction

    // Issue one A-channel request; dly = REG cycle on which ack_i is given
    // (beyond TO means never), hold = d_ready low cycles in RESP.
    task automatic send(input logic [2:0] op, input logic [1:0] size, input logic [7:0] src,
                        input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                        input int dly, input logic [31:0] rd, input logic ei, input int hold,
                        input bit push_rsp);
        logic err, get, acked, e;
        int k, w, acc;
        rsp_t r;
        req_t q;
        err = m_err(op, size, addr, mask);
        get = (op == Get);
        acked = (dly <= TO);
        k = acked ? dly : TO;
        e = err ? 1'b1 : (acked ? ei : 1'b1);
        @(negedge clk);
        drv_valid = 1'b1; drv_op = op; drv_size = size; drv_src = src;
        drv_addr = addr; drv_mask = mask; drv_data = data;
        w = 0;
        while (!tl_o.a_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            chk("a_ready_wait", 64'd0, 64'd1);
            drv_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            drv_valid = 1'b0;
            acc = cyc;
            r = '{op: get ? AccessAckData : AccessAck, size: size, src: src,
                  data: !get ? 32'h0 : (e ? 32'hFFFF_FFFF : rd), err: e,
                  cyc: acc + (err ? 0 : k), hold: hold};
            if (push_rsp) rsp_q.push_back(r);
            if (!err) begin
                q = '{we: !get, addr: addr[AW-1:0] & ~12'h3, wdata: data,
                      be: get ? 4'hF : mask, dly: dly, rd: rd, ei: ei};
                req_q.push_back(q);
            end
        end
    endtask

    // Register-bus responder: checks each access and acks after its planned delay.
    req_t cur;
    bit   active = 1'b0;
    int   k_cnt = 0;
    always @(negedge clk) begin
        ack_i = 1'b0;
        error_i = 1'b0;
        rdata_i = $urandom;
        if (!rst_ni) begin
            active = 1'b0;
        end else if (req_o) begin
            if (!active) begin
                active = 1'b1;
                k_cnt = 0;
                if (req_q.size() == 0) begin
                    chk("req_unexpected", 64'd1, 64'd0);
                    cur = '{we: 1'b0, addr: '0, wdata: 32'h0, be: 4'h0, dly: 1, rd: 32'h0, ei: 1'b0};
                end else begin
                    cur = req_q.pop_front();
                    chk("req_we", we_o, cur.we);
                    chk("req_addr", addr_o, cur.addr);
                    chk("req_wdata", wdata_o, cur.wdata);
                    chk("req_be", be_o, cur.be);
                end
            end else begin
                chk("req_stable", {we_o, addr_o, wdata_o, be_o}, {cur.we, cur.addr, cur.wdata, cur.be});
            end
            k_cnt++;
            if (k_cnt == cur.dly) begin
                ack_i = 1'b1;
                rdata_i = cur.rd;
                error_i = cur.ei;
            end
        end else begin
            if (active) begin
                active = 1'b0;
                chk("req_len", k_cnt, (cur.dly <= TO) ? cur.dly : TO);
            end
            // Stray acks outside a request must be ignored.
            if ($urandom % 8 == 0) begin
                ack_i = 1'b1;
                error_i = 1'($urandom);
            end
        end
    end

    // D-channel monitor: compares responses, checks stability, drives d_ready.
    rsp_t    er;
    tl_d2h_t saved;
    bit      mon_active = 1'b0;
    bit      hs_pending = 1'b0;
    int      hold_left = 0;
    always @(negedge clk) begin
        if (!rst_ni) begin
            mon_active = 1'b0;
            hs_pending = 1'b0;
            drv_dready = 1'b0;
        end else begin
            if (hs_pending) begin
                hs_pending = 1'b0;
                chk("a_ready_after_rsp", {tl_o.a_ready, tl_o.d_valid}, 2'b10);
            end
            if (tl_o.d_valid) begin
                if (!mon_active) begin
                    if (rsp_q.size() == 0) begin
                        chk("rsp_unexpected", 64'd1, 64'd0);
                        hold_left = 0;
                    end else begin
                        er = rsp_q.pop_front();
                        chk("d_opcode", tl_o.d_opcode, er.op);
                        chk("d_size", tl_o.d_size, er.size);
                        chk("d_source", tl_o.d_source, er.src);
                        chk("d_data", tl_o.d_data, er.data);
                        chk("d_error", tl_o.d_error, er.err);
                        chk("d_param_sink", {tl_o.d_param, tl_o.d_sink}, 4'h0);
                        chk("rsp_cycle", cyc, er.cyc);
                        hold_left = er.hold;
                    end
                    mon_active = 1'b1;
                    saved = tl_o;
                end else begin
                    chk("d_stable", tl_o, saved);
                end
                if (hold_left == 0) begin
                    drv_dready = 1'b1;
                    mon_active = 1'b0;
                    hs_pending = 1'b1;
                end else begin
                    drv_dready = 1'b0;
                    hold_left--;
                end
            end else begin
                drv_dready = 1'($urandom);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [3:0]  mask;
        int r, w;

        repeat (3) @(negedge clk);
        chk("rst_tl_o", tl_o, 52'h0);
        chk("rst_regbus", {req_o, we_o, addr_o, wdata_o, be_o}, 50'h0);
        #2 rst_ni = 1'b1;
        @(negedge clk);
        chk("a_ready_out_of_rst", tl_o.a_ready, 1'b1);

        // Get with ack on the third REG cycle
        send(Get, 2'd2, 8'h5A, 32'h10, 4'hF, 32'h0, 3, 32'hDEADBEEF, 1'b0, 0, 1'b1);
        // Full-word write
        send(PutFullData, 2'd2, 8'h11, 32'h8, 4'hF, 32'h12345678, 2, 32'h0, 1'b0, 0, 1'b1);
        // Misaligned Get and illegal opcode are filtered
        send(Get, 2'd2, 8'h22, 32'h2, 4'hF, 32'h0, 1, 32'h0, 1'b0, 0, 1'b1);
        send(3'h2, 2'd2, 8'h23, 32'h0, 4'hF, 32'h0, 1, 32'h0, 1'b0, 0, 1'b1);
        // Timeout, then ack exactly on the last permitted cycle
        send(Get, 2'd2, 8'h30, 32'h20, 4'hF, 32'h0, TO + 5, 32'h0, 1'b0, 0, 1'b1);
        send(Get, 2'd2, 8'h31, 32'h24, 4'hF, 32'h0, TO, 32'hCAFEF00D, 1'b0, 0, 1'b1);
        // Register error, partial write, stalled d_ready then back-to-back
        send(Get, 2'd2, 8'h40, 32'h28, 4'hF, 32'h0, 1, 32'h55AA55AA, 1'b1, 0, 1'b1);
        send(PutPartialData, 2'd0, 8'h41, 32'h3, 4'h8, 32'hAB000000, 1, 32'h0, 1'b0, 0, 1'b1);
        send(Get, 2'd2, 8'h50, 32'h30, 4'hF, 32'h0, 1, 32'h01020304, 1'b0, 5, 1'b1);
        send(Get, 2'd1, 8'h51, 32'h32, 4'hC, 32'h0, 2, 32'hA5A5A5A5, 1'b0, 0, 1'b1);

        // Reset during REG abandons the transaction
        send(Get, 2'd2, 8'h60, 32'h40, 4'hF, 32'h0, 100, 32'h0, 1'b0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("req_before_rst", req_o, 1'b1);
        #2 rst_ni = 1'b0;
        #1 chk("rst_async_drop", {req_o, tl_o.d_valid, tl_o.a_ready}, 3'b000);
        @(negedge clk);
        @(negedge clk);
        #2 rst_ni = 1'b1;
        @(negedge clk);
        chk("a_ready_after_mid_rst", tl_o.a_ready, 1'b1);
        send(Get, 2'd2, 8'h61, 32'h44, 4'hF, 32'h0, 2, 32'h0BADCAFE, 1'b0, 0, 1'b1);

        for (int t = 0; t < 200; t++) begin
            r = int'($urandom % 10);
            case (r)
                0, 1, 2: op = Get;
                3, 4:    op = PutFullData;
                5, 6:    op = PutPartialData;
                default: op = 3'($urandom);
            endcase
            sz = ($urandom % 6 == 0) ? 2'd3 : 2'($urandom % 3);
            addr = $urandom;
            if ($urandom % 4 != 0 && sz != 2'd3) addr = addr & ~((32'd1 << sz) - 32'd1);
            if ($urandom % 3 != 0) begin
                mask = m_lane(sz, addr);
                if (op == PutPartialData && $urandom % 2 == 0) mask = mask & 4'($urandom);
            end else begin
                mask = 4'($urandom);
            end
            send(op, sz, 8'($urandom), addr, mask, $urandom, 1 + int'($urandom % 10),
                 $urandom, 1'($urandom % 5 == 0), int'($urandom % 4), 1'b1);
        end

        w = 0;
        while ((rsp_q.size() != 0 || tl_o.d_valid || req_o) && w < 300) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        chk("rsp_queue_drained", rsp_q.size(), 0);
        chk("req_queue_drained", req_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
